// File: rtl/vernam_pkg.sv
// Shared constants and types for the ciphertext UART transmitter.
package vernam_pkg;

  localparam logic [7:0] PORT_DATA_ADDR   = 8'h10;
  localparam logic [7:0] PORT_STATUS_ADDR = 8'h11;
  localparam int         OVF_CLR_BIT      = 2;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

  function automatic logic [3:0] sat_count(
    input logic [4:0] c
  );
    return (c > 5'd15) ? 4'd15 : c[3:0];
  endfunction

endpackage

// File: rtl/tx_fifo.sv
// Byte FIFO buffering ciphertext ahead of the serialiser.
module tx_fifo #(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign dout    = mem_q[rd_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    wr_d  = do_push ? wr_q + AW'(1) : wr_q;
    rd_d  = do_pop ? rd_q + AW'(1) : rd_q;
    cnt_d = cnt_q;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/cipher_tx_uart.sv
// Port-mapped 8N1 transmitter draining a ciphertext FIFO,
// with overflow flag and drain-complete interrupt.
module cipher_tx_uart
  import vernam_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [7:0]  PORT_DATA    = PORT_DATA_ADDR,
  parameter logic [7:0]  PORT_STATUS  = PORT_STATUS_ADDR
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] port_id,
  input  logic [7:0] out_port,
  input  logic       write_strobe,
  input  logic       irq_ack,
  output logic [7:0] status,
  output logic       irq,
  output logic       tx
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = (CLKS_PER_BIT > 2) ?
                      $clog2(CLKS_PER_BIT) : 1;

  tx_state_e     state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          tx_q, tx_d;
  logic          irq_q, irq_d;
  logic          ovf_q, ovf_d;

  logic          push_req, push, drop, clr;
  logic          pop, irq_set, last;
  logic          full, empty;
  logic [7:0]    head;
  logic [CW-1:0] count;

  assign push_req = write_strobe & (port_id == PORT_DATA);
  assign push     = push_req & ~full;
  assign drop     = push_req & full;
  assign clr      = write_strobe & (port_id == PORT_STATUS)
                  & out_port[OVF_CLR_BIT];
  assign last     = (baud_q == BW'(CLKS_PER_BIT - 1));

  tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (out_port),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      irq_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      irq_q   <= irq_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    pop     = 1'b0;
    irq_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shreg_d = head;
          baud_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      DATA: begin
        if (last) begin
          baud_d  = '0;
          shreg_d = shreg_q >> 1;
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      STOP: begin
        if (last) begin
          baud_d = '0;
          // Back-to-back frames: reload straight into START.
          if (!empty) begin
            pop     = 1'b1;
            shreg_d = head;
            state_d = START;
          end else begin
            state_d = IDLE;
            irq_set = ~push;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      default: tx_d = 1'b1;
    endcase
    irq_d = irq_set | (irq_q & ~irq_ack);
    ovf_d = drop | (ovf_q & ~clr);
  end

  assign status = {sat_count(5'(count)), state_q != IDLE,
                   ovf_q, full, empty};
  assign irq    = irq_q;
  assign tx     = tx_q;

endmodule

// File: doc/cipher_tx_uart.md
CIPHER_TX_UART -- requirements
Module: cipher_tx_uart

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, meaning clock cycles per serial bit (legal >= 2).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning ciphertext bytes buffered (power of two, 2..16).
REQ-003 SHALL have parameter PORT_DATA, default 8'h10, meaning port_id that pushes a byte.
REQ-004 SHALL have parameter PORT_STATUS, default 8'h11, meaning port_id that writes the control byte.
REQ-005 SHALL have port clk  in  1  clock, all logic rising-edge.
REQ-006 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port port_id  in  8  processor port address.
REQ-008 SHALL have port out_port  in  8  processor write data.
REQ-009 SHALL have port write_strobe  in  1  processor write qualifier, one cycle.
REQ-010 SHALL have port irq_ack  in  1  processor interrupt acknowledge.
REQ-011 SHALL have port status  out  8  status byte for the processor input mux.
REQ-012 SHALL have port irq  out  1  drain-complete interrupt, level.
REQ-013 SHALL have port tx  out  1  serial line, 8N1, idle high.

Function
REQ-014 SHALL push out_port into the FIFO when write_strobe=1, port_id==PORT_DATA and FIFO not full (pre-edge state).
REQ-015 SHALL drop a PORT_DATA write when FIFO full and set sticky overflow; FIFO contents unchanged.
REQ-016 SHALL clear overflow when write_strobe=1, port_id==PORT_STATUS and out_port[2]=1; set by a dropped write in the same cycle wins.
REQ-017 SHALL drive status = {count[3:0], busy, overflow, full, empty}, bits [7:4]..[0], combinational from registers; count saturates at 15 in the field.
REQ-018 SHALL use FSM states IDLE, START, DATA, STOP; busy=1 in all but IDLE.
REQ-019 SHALL, in IDLE with FIFO non-empty, pop head into shift register and go to START; tx falls on the 2nd rising edge after the accepting write cycle.
REQ-020 SHALL hold each of START (tx=0), 8 DATA bits (LSB first), STOP (tx=1) for exactly CLKS_PER_BIT cycles; frame = 10*CLKS_PER_BIT cycles.
REQ-021 SHALL, at the end of STOP with FIFO non-empty, pop and enter START directly (no idle cycle between frames).
REQ-022 SHALL allow simultaneous push and pop; count unchanged, order preserved, pointers wrap modulo FIFO_DEPTH.
REQ-023 SHALL set irq at the end of STOP when FIFO empty and no push occurs in that cycle; irq held until irq_ack=1, which clears it next edge; set wins over simultaneous ack.
REQ-024 SHALL ignore writes to any other port_id and ignore write_strobe=0.

Reset
REQ-025 SHALL, on reset, set state IDLE, tx=1, irq=0, overflow=0, FIFO empty (pointers 0, count 0), baud and bit counters 0; status=8'h01.
REQ-026 SHALL abort a frame in progress on reset; tx returns high on the reset edge, partial frame is not resumed.
REQ-027 SHALL give reset priority over all writes and acks in the same cycle.

Structure
REQ-028 SHALL place port address constants and the FSM state enum in shared package vernam_pkg.
REQ-029 SHALL implement the buffer as sub-module tx_fifo (push, pop, data in/out, full, empty, count).
REQ-030 SHALL register tx directly from a flop (no combinational glitch path).

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=8)
REQ-031 SHALL cover: single write 8'hA5 to 8'h10 -> tx low 2 edges later, line samples 0,1,0,1,0,0,1,0,1,1 per 4 cycles, then irq=1.
REQ-032 SHALL cover: 3 back-to-back writes 8'h01,8'h02,8'h03 -> 3 contiguous 40-cycle frames, no idle gap, bytes in order, one irq after third.
REQ-033 SHALL cover: 10 writes while first frame in flight -> 9 accepted (1 popped + 8 buffered), 10th dropped, status[2]=1, status[1]=1; write 8'h04 to 8'h11 clears overflow.
REQ-034 SHALL cover: irq=1 and irq_ack pulsed -> irq=0 next edge; ack coinciding with new drain completion -> irq stays 1.
REQ-035 SHALL cover: reset asserted at DATA bit 3 -> tx=1, status=8'h01, irq=0 next edge; subsequent write transmits a clean full frame.
